mod_counter: RTL and testbench

- Parametrised successor to the team's fixed 6-bit free-running counter.
- Modulo-N up/down counter with:
  - synchronous clear and parallel load
  - selectable wrap or saturate at the bounds
  - terminal-count flag and a sticky overflow flag
- Used across the IEEE-754 datapath for exponent/shift-step sequencing, iteration counting in multi-cycle operations, and general timing.

---
 rtl/mod_counter_if.sv | 30 +++
 rtl/mod_counter.sv | 88 ++++++++
 tb/tb_mod_counter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter_if
// Brief    : Control/status bundle for mod_counter; master drives controls,
//            slave (the counter) returns count, tc and ovf.
// Revision : 1.0 - initial release
// ============================================================================
interface mod_counter_if #(
    parameter int WIDTH = 6
);
    logic             clr;
    logic             enb;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;

    modport master (
        output clr, enb, up, load, load_val,
        input  count, tc, ovf
    );

    modport slave (
        input  clr, enb, up, load, load_val,
        output count, tc, ovf
    );
endinterface
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter
// Brief    : Modulo-N up/down counter with clear, clamped load, wrap or
//            saturate, terminal count and sticky overflow. Optional enable
//            prescaler built when CNT_PRESCALE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mod_counter #(
    parameter int WIDTH    = 6,
    parameter int MODULUS  = 64,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 4
) (
    input  logic          clk,
    input  logic          res,
    mod_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 1);

    generate
        if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
            $error("mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("mod_counter: PRESCALE must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic             w_pre_term;
    logic             w_at_bound;
    logic             w_step;

`ifdef CNT_PRESCALE_EN
    localparam int              c_pw       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_pw-1:0] c_pre_last = c_pw'(PRESCALE - 1);

    logic [c_pw-1:0] r_pre;

    assign w_pre_term = (r_pre == c_pre_last);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_pre <= '0;
        end else if (bus.clr || bus.load) begin
            r_pre <= '0;
        end else if (bus.enb) begin
            r_pre <= w_pre_term ? '0 : r_pre + c_pw'(1);
        end
    end
`else
    assign w_pre_term = 1'b1;
`endif

    // Boundary depends on direction only; tc fires on the edge that wraps/saturates.
    assign w_at_bound = bus.up ? (r_count == c_max) : (r_count == '0);
    assign w_step     = bus.enb & ~bus.clr & ~bus.load & w_pre_term;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (bus.clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (bus.load) begin
            r_count <= (bus.load_val > c_max) ? c_max : bus.load_val;
        end else if (w_step) begin
            if (w_at_bound) begin
                r_ovf <= 1'b1;
                if (SATURATE == 0) begin
                    r_count <= bus.up ? '0 : c_max;
                end
            end else begin
                r_count <= bus.up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
            end
        end
    end

    assign bus.count = r_count;
    assign bus.ovf   = r_ovf;
    assign bus.tc    = w_step & w_at_bound;

endmodule
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_counter
// Brief    : Self-checking bench for mod_counter (directed table, hand
//            sequences and randomized run against an integer reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_counter;

    logic clk;
    logic res;
    int   n_vec;
    int   n_err;

    mod_counter_if #(.WIDTH(6)) b0 ();
    mod_counter_if #(.WIDTH(6)) b1 ();
    mod_counter_if #(.WIDTH(6)) b2 ();
    mod_counter_if #(.WIDTH(6)) b3 ();

    mod_counter #(.WIDTH(6), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u_wrap10 (.clk(clk), .res(res), .bus(b0));
    mod_counter #(.WIDTH(6), .MODULUS(10), .SATURATE(1), .PRESCALE(1)) u_sat10  (.clk(clk), .res(res), .bus(b1));
    mod_counter #(.WIDTH(6), .MODULUS(64), .SATURATE(0), .PRESCALE(1)) u_wrap64 (.clk(clk), .res(res), .bus(b2));
    mod_counter #(.WIDTH(6), .MODULUS(64), .SATURATE(0), .PRESCALE(4)) u_pre4   (.clk(clk), .res(res), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit clr;
        bit load;
        bit enb;
        bit up;
        int lv;
        int cnt;
        bit tc;
        bit ovf;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit c, bit l, bit e, bit u, int lv, int cnt, bit tc, bit ovf);
        vec_t v;
        v.clr = c; v.load = l; v.enb = e; v.up = u; v.lv = lv;
        v.cnt = cnt; v.tc = tc; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the counting rules.
    function automatic bit model_tc(int m, int c, bit clr, bit load, bit enb, bit up);
        return enb && !clr && !load && (up ? (c == m - 1) : (c == 0));
    endfunction

    task automatic model_next(input int m, input bit sat, input bit clr, input bit load,
                              input bit enb, input bit up, input int lv,
                              inout int c, inout bit o);
        if (clr) begin
            c = 0; o = 0;
        end else if (load) begin
            c = (lv < m) ? lv : m - 1;
        end else if (enb) begin
            if (up) begin
                if (c + 1 < m) c = c + 1;
                else begin o = 1; if (!sat) c = 0; end
            end else begin
                if (c - 1 >= 0) c = c - 1;
                else begin o = 1; if (!sat) c = m - 1; end
            end
        end
    endtask

    task automatic idle_all();
        b0.clr = 0; b0.load = 0; b0.enb = 0; b0.up = 1; b0.load_val = '0;
        b1.clr = 0; b1.load = 0; b1.enb = 0; b1.up = 1; b1.load_val = '0;
        b2.clr = 0; b2.load = 0; b2.enb = 0; b2.up = 1; b2.load_val = '0;
        b3.clr = 0; b3.load = 0; b3.enb = 0; b3.up = 1; b3.load_val = '0;
    endtask

    task automatic edge_and_settle();
        @(posedge clk);
        #1;
    endtask

    int m0c, m1c;
    bit m0o, m1o;

    initial begin
        n_vec = 0;
        n_err = 0;
        res   = 1'b0;
        idle_all();

        // ---------------- directed table for the MODULUS=10 wrap counter
        for (int i = 0; i < 12; i++)
            vt.push_back(mk(0, 0, 1, 1, 0, (i + 1) % 10, (i == 9), (i >= 9)));
        vt.push_back(mk(0, 1, 0, 1, 5,  5, 0, 1));
        vt.push_back(mk(1, 1, 1, 1, 7,  0, 0, 0));
        vt.push_back(mk(0, 1, 0, 1, 15, 9, 0, 0));
        vt.push_back(mk(0, 1, 1, 1, 3,  3, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 0,  4, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 0,  4, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 0,  4, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 0,  5, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 0,  4, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 0,  9, 1, 1));
        vt.push_back(mk(0, 0, 1, 1, 0,  0, 1, 1));
        vt.push_back(mk(1, 0, 1, 0, 0,  0, 0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_count", 32'(b0.count), 0);
        chk("reset_ovf",   32'(b0.ovf),   0);
        res = 1'b1;

        // ---------------- asynchronous reset mid-count
        @(negedge clk);
        b2.load = 1; b2.load_val = 6'd23;
        edge_and_settle();
        b2.load = 0;
        chk("preload_23", 32'(b2.count), 23);
        #2 res = 1'b0;
        #1;
        chk("async_rst_count", 32'(b2.count), 0);
        chk("async_rst_ovf",   32'(b2.ovf),   0);
        @(negedge clk);
        res = 1'b1;

        // ---------------- table
        foreach (vt[i]) begin
            @(negedge clk);
            b0.clr = vt[i].clr; b0.load = vt[i].load; b0.enb = vt[i].enb;
            b0.up  = vt[i].up;  b0.load_val = 6'(vt[i].lv);
            #1;
            chk($sformatf("tbl%0d_tc", i), 32'(b0.tc), 32'(vt[i].tc));
            edge_and_settle();
            chk($sformatf("tbl%0d_count", i), 32'(b0.count), 32'(vt[i].cnt));
            chk($sformatf("tbl%0d_ovf", i),   32'(b0.ovf),   32'(vt[i].ovf));
        end
        @(negedge clk);
        idle_all();

        // ---------------- down-saturate: 2,1,0,0,0
        b1.load = 1; b1.load_val = 6'd2;
        edge_and_settle();
        chk("dsat_load", 32'(b1.count), 2);
        @(negedge clk);
        b1.load = 0; b1.up = 0; b1.enb = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("dsat%0d_tc", k), 32'(b1.tc), (k >= 2) ? 1 : 0);
            edge_and_settle();
            chk($sformatf("dsat%0d_count", k), 32'(b1.count), (k < 2) ? 1 - k : 0);
            chk($sformatf("dsat%0d_ovf", k),   32'(b1.ovf),   (k >= 2) ? 1 : 0);
            @(negedge clk);
        end
        b1.enb = 0;

        // ---------------- full-width wrap and direction flip
        b2.load = 1; b2.load_val = 6'd63;
        edge_and_settle();
        @(negedge clk);
        b2.load = 0; b2.up = 1; b2.enb = 1;
        #1;
        chk("fw_tc_up", 32'(b2.tc), 1);
        edge_and_settle();
        chk("fw_wrap_count", 32'(b2.count), 0);
        chk("fw_wrap_ovf",   32'(b2.ovf),   1);
        @(negedge clk);
        b2.up = 0;
        #1;
        chk("fw_tc_dn", 32'(b2.tc), 1);
        edge_and_settle();
        chk("fw_flip_count", 32'(b2.count), 63);
        chk("fw_flip_ovf",   32'(b2.ovf),   1);
        @(negedge clk);
        b2.enb = 0;

        // ---------------- randomized run against the reference model
        b0.clr = 1; b1.clr = 1;
        edge_and_settle();
        m0c = 0; m0o = 0; m1c = 0; m1o = 0;
        for (int r = 0; r < 400; r++) begin
            bit c, l, e, u;
            int lv;
            @(negedge clk);
            c  = ($urandom_range(0, 19) == 0);
            l  = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = ($urandom_range(0, 1) == 1);
            lv = $urandom_range(0, 63);
            b0.clr = c; b0.load = l; b0.enb = e; b0.up = u; b0.load_val = 6'(lv);
            b1.clr = c; b1.load = l; b1.enb = e; b1.up = u; b1.load_val = 6'(lv);
            #1;
            chk("rnd_wrap_tc", 32'(b0.tc), 32'(model_tc(10, m0c, c, l, e, u)));
            chk("rnd_sat_tc",  32'(b1.tc), 32'(model_tc(10, m1c, c, l, e, u)));
            model_next(10, 0, c, l, e, u, lv, m0c, m0o);
            model_next(10, 1, c, l, e, u, lv, m1c, m1o);
            edge_and_settle();
            chk("rnd_wrap_count", 32'(b0.count), 32'(m0c));
            chk("rnd_wrap_ovf",   32'(b0.ovf),   32'(m0o));
            chk("rnd_sat_count",  32'(b1.count), 32'(m1c));
            chk("rnd_sat_ovf",    32'(b1.ovf),   32'(m1o));
        end
        @(negedge clk);
        idle_all();

`ifdef CNT_PRESCALE_EN
        // ---------------- prescaler: steps on the 4th and 8th enabled cycle
        b3.clr = 1;
        edge_and_settle();
        @(negedge clk);
        b3.clr = 0; b3.enb = 1; b3.up = 1;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk($sformatf("pre%0d_tc", k), 32'(b3.tc), 0);
            edge_and_settle();
            chk($sformatf("pre%0d_count", k), 32'(b3.count), (k < 4) ? 0 : ((k < 8) ? 1 : 2));
            @(negedge clk);
        end
        // load on the second enabled cycle restarts the divider
        b3.clr = 1;
        edge_and_settle();
        @(negedge clk);
        b3.clr = 0;
        edge_and_settle();
        @(negedge clk);
        b3.load = 1; b3.load_val = 6'd10;
        edge_and_settle();
        @(negedge clk);
        b3.load = 0;
        for (int k = 1; k <= 4; k++) begin
            edge_and_settle();
            chk($sformatf("preld%0d_count", k), 32'(b3.count), (k < 4) ? 10 : 11);
            @(negedge clk);
        end
        idle_all();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
